// File: rtl/im_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader_pkg
//  Description : Shared constants and FSM state encoding for the IM loader.
//  Revision    : 1.0  initial release
// ============================================================================
package im_loader_pkg;

    localparam logic [15:0] c_code_seg_pc = 16'h3000;
    localparam int          c_im_words    = 8192;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/im_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader_byte_packer
//  Description : 8->32 big-endian shift register with a 2-bit byte counter.
//  Revision    : 1.0  initial release
// ============================================================================
module im_loader_byte_packer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word_out,
    output logic              full
);

    logic [DATA_W-1:0] r_word;
    logic [1:0]        r_cnt;

    // Shifting left places the first byte of the word in the MSB lane.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= '0;
            r_cnt  <= 2'd0;
        end else begin
            if (clr)
                r_cnt <= 2'd0;
            else if (shift_en)
                r_cnt <= r_cnt + 2'd1;
            if (shift_en)
                r_word <= {r_word[DATA_W-9:0], byte_in};
        end
    end

    assign word_out = r_word;
    assign full     = shift_en && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module      : im_loader
//  Description : Packs a byte stream into 32-bit words and writes them to IM.
//  Revision    : 1.0  initial release
// ============================================================================
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_din,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);

    state_t            r_state;
    logic              r_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_busy;
    logic              r_done;

    logic              w_shift;
    logic              w_full;
    logic              w_clr;
    logic [ADDR_W-1:0] w_base_aligned;

    assign w_base_aligned = base_addr & ~ADDR_W'(3);
    assign w_shift        = byte_valid && r_ready;
    assign w_clr          = (r_state == S_WRITE);

    im_loader_byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_clr),
        .shift_en (w_shift),
        .byte_in  (byte_data),
        .word_out (im_din),
        .full     (w_full)
    );

    // Outputs are registered with the state so they change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr      <= w_base_aligned;
                        r_remaining <= word_count;
                        if (word_count == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_COLLECT;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                S_COLLECT: begin
                    if (w_full) begin
                        r_state <= S_WRITE;
                        r_ready <= 1'b0;
                        r_we    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_we        <= 1'b0;
                    r_addr      <= r_addr + c_addr_step;
                    r_remaining <= r_remaining - CNT_W'(1);
                    if (r_remaining == CNT_W'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_COLLECT;
                        r_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign im_we      = r_we;
    assign im_addr    = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: doc/im_loader.md
Name: im_loader

Overview:
- Program loader that fills the instruction memory (im_32k) from an external byte stream before the CPU runs.
- Packs incoming bytes big-endian into 32-bit words and issues one write per word to the IM write port.
- Writes start at a word-aligned base address and step by 4.
- Stands at the write end of the IM interface; fetch/test logic reads back the same words through addr/dout.

Parameters:
- ADDR_W, 16, IM byte-address width (matches im_32k addr).
- DATA_W, 32, instruction word width.
- CNT_W, 14, width of word_count (max 8192 words = 32 KiB).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  single-cycle pulse; begins a load (sampled only in IDLE or DONE).
- base_addr  input  ADDR_W  first word byte address; bits [1:0] ignored (forced 00).
- word_count  input  CNT_W  number of words to load; sampled with start.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  IM write enable, one-cycle pulse per word.
- im_addr  output  ADDR_W  IM write byte address.
- im_din  output  DATA_W  IM write data.
- busy  output  1  high from the cycle after an accepted start until DONE is entered.
- done  output  1  high in DONE; held until the next start or reset.

Behaviour:
- Reset (async, any state): state=IDLE. byte_ready=0, im_we=0, im_addr=0, im_din=0, busy=0, done=0. Byte counter cleared. Partial word discarded; no write is issued.
- A byte is accepted when byte_valid && byte_ready are both high on a posedge.
- IDLE/DONE:
  - On start: latch addr={base_addr[15:2],2'b00} and remaining=word_count; clear done.
  - If word_count==0, go directly to DONE; done is asserted the next cycle and busy stays 0.
  - Otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - Accepted byte k (0..3) is placed at im_din[31-8k -: 8]; the first byte is the MSB.
  - On the 4th accepted byte, go to WRITE.
  - No timeout: byte_valid low simply stalls the state.
- WRITE (exactly 1 cycle):
  - byte_ready=0, im_we=1, with im_addr and im_din stable for the whole cycle.
  - At the end of the cycle: addr += 4 (wraps modulo 2^16, no error); remaining -= 1; byte counter cleared.
  - If remaining becomes 0, go to DONE; else go to COLLECT.
- Throughput: 5 cycles per word at best (4 accept cycles + 1 write cycle).
- Latency: im_we asserts the cycle after the 4th byte is accepted.
- start while busy is ignored. A byte_valid with no active load is not accepted (byte_ready=0).
- done=1 only in DONE; busy=1 only in COLLECT/WRITE.
- A new start from DONE re-arms the load with no extra idle cycle.

Decomposition:
- Shared header im_defs.v:
  - CODE_SEG_PC (16'h3000).
  - State encodings S_IDLE, S_COLLECT, S_WRITE, S_DONE (2 bits).
  - IM_WORDS constant (8192).
- Sub-module byte_packer: 8→32 shift register with a 2-bit byte counter. Inputs: clk, rst, clr, shift_en, byte_in. Outputs: word_out, full.
- The top-level FSM in im_loader owns the address and remaining-word counters.

Test Plan:
- Basic load:
  - Stimulus: rst pulse; start with base 0x3000, count 10. Stream bytes 00,01,02,...,27 with byte_valid held high.
  - Required: 10 im_we pulses at 0x3000, 0x3004, ..., 0x3024. Data 00010203, 04050607, ..., 24252627 (each +04040404). done=1 after the last write. IM readback from 0x3000 matches.
- Stall:
  - Stimulus: same load as above, with byte_valid toggled 1/0 every cycle.
  - Required: identical writes; no byte dropped or duplicated; one im_we per 4 accepted bytes.
- Zero count and misaligned base:
  - Stimulus: count 0.
  - Required: DONE the next cycle; im_we never asserts; busy never asserts.
  - Stimulus: base 0x3003, count 1, bytes DE AD BE EF.
  - Required: write DEADBEEF at 0x3000.
- Reset mid-word:
  - Stimulus: rst asserted after 2 bytes of word 3.
  - Required: all outputs go to 0 immediately; no write for the partial word. A new start at 0x4000 with count 1 then writes a fresh word at 0x4000.
- Address wrap and ignored start:
  - Stimulus: base 0xFFFC, count 2, bytes 11..18; a second start pulse is issued mid-load.
  - Required: writes 11121314 at 0xFFFC and 15161718 at 0x0000. The second start has no effect. done=1 at the end.
